// File: rtl/uart_dbg_pkg.sv
// Shared constants and types for the UART debug link (command decoder and trace transmitter).
//   BYTE_W / WORD_W       : serial byte and memory word widths
//   ADDR_BYTES/DATA_BYTES : bytes per address / data field of a frame
//   CMD_*                 : host command bytes (uppercase ASCII)
//   dbg_state_e           : decoder frame state
//   mem_req_t             : memory request payload
package uart_dbg_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_BYTES = 4;
  localparam int unsigned DATA_BYTES = 4;
  localparam int unsigned BCNT_W     = 2;
  localparam int unsigned ERR_CNT_W  = 8;

  localparam logic [BYTE_W-1:0] CMD_GO    = 8'h47; // 'G'
  localparam logic [BYTE_W-1:0] CMD_HALT  = 8'h48; // 'H'
  localparam logic [BYTE_W-1:0] CMD_STEP  = 8'h53; // 'S'
  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57; // 'W'
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52; // 'R'

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ISSUE = 2'd3
  } dbg_state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Big-endian field assembly: earlier bytes migrate toward the MSBs.
  function automatic logic [WORD_W-1:0] shift_in_byte(input logic [WORD_W-1:0] word,
                                                      input logic [BYTE_W-1:0] b);
    return {word[WORD_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter for frames in progress.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : restart the count (byte accepted or not inside a frame)
//   en_i          : count this cycle
//   expired_o     : count has reached TIMEOUT_CYCLES-1
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 2700000,
  parameter int unsigned TIMEOUT_W      = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 expired_q;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  // Expired flag is registered alongside the count so it tracks cnt_q exactly.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Host command frame decoder: turns UART bytes into run/halt/step controls and
// 32-bit memory read/write requests.
//   sys_clk, sys_rst_n               : clock, synchronous active-low reset
//   rx_data, rx_data_valid           : byte stream from uart_rx
//   o_rx_data_ready                  : byte accepted when valid && ready
//   o_run, o_step                    : core free-run level / single-step pulse
//   o_req_* , req_ready              : memory request handshake
//   o_err, o_err_cnt                 : framing error pulse / saturating count
//   o_busy                           : a frame or request is in progress
module uart_cmd_decoder
  import uart_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2700000,
  parameter int unsigned TIMEOUT_W      = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [BYTE_W-1:0]    rx_data,
  input  logic                 rx_data_valid,
  output logic                 o_rx_data_ready,
  output logic                 o_run,
  output logic                 o_step,
  output logic                 o_req_valid,
  output logic                 o_req_we,
  output logic [WORD_W-1:0]    o_req_addr,
  output logic [WORD_W-1:0]    o_req_wdata,
  input  logic                 req_ready,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic                 o_busy
);

  dbg_state_e           state_q, state_d;
  mem_req_t             req_q, req_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 run_q, run_d;
  logic                 step_q, step_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  logic accept;
  logic in_frame;
  logic tmo_expired;

  assign accept   = rx_data_valid && rdy_q;
  assign in_frame = (state_q == ADDR) || (state_q == DATA);

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_timeout (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .clr_i     (accept || !in_frame),
    .en_i      (in_frame),
    .expired_o (tmo_expired)
  );

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    bcnt_d    = bcnt_q;
    run_d     = run_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (rx_data)
            CMD_GO:    run_d  = 1'b1;
            CMD_HALT:  run_d  = 1'b0;
            CMD_STEP:  step_d = 1'b1;
            CMD_WRITE, CMD_READ: begin
              req_d.we = (rx_data == CMD_WRITE);
              bcnt_d   = '0;
              state_d  = ADDR;
            end
            default:   err_d  = 1'b1;
          endcase
        end
      end
      ADDR: begin
        if (accept) begin
          req_d.addr = shift_in_byte(req_q.addr, rx_data);
          if (bcnt_q == BCNT_W'(ADDR_BYTES - 1)) begin
            bcnt_d = '0;
            if (req_q.we) begin
              state_d = DATA;
            end else begin
              req_d.wdata = '0;
              state_d     = ISSUE;
            end
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (accept) begin
          req_d.wdata = shift_in_byte(req_q.wdata, rx_data);
          if (bcnt_q == BCNT_W'(DATA_BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = ISSUE;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (req_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    // Status outputs are registered from the upcoming state.
    valid_d = (state_d == ISSUE);
    rdy_d   = (state_d != ISSUE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      bcnt_q    <= '0;
      err_cnt_q <= '0;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      bcnt_q    <= bcnt_d;
      err_cnt_q <= err_cnt_d;
      run_q     <= run_d;
      step_q    <= step_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign o_rx_data_ready = rdy_q;
  assign o_run           = run_q;
  assign o_step          = step_q;
  assign o_req_valid     = valid_q;
  assign o_req_we        = req_q.we;
  assign o_req_addr      = req_q.addr;
  assign o_req_wdata     = req_q.wdata;
  assign o_err           = err_q;
  assign o_err_cnt       = err_cnt_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed scenarios plus randomized
// frames, checked every cycle against a frame-level reference model.
module tb_uart_cmd_decoder;

  localparam int unsigned TMO = 50;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        o_rx_data_ready;
  logic        o_run;
  logic        o_step;
  logic        o_req_valid;
  logic        o_req_we;
  logic [31:0] o_req_addr;
  logic [31:0] o_req_wdata;
  logic        req_ready;
  logic        o_err;
  logic [7:0]  o_err_cnt;
  logic        o_busy;

  int n_vec  = 0;
  int n_miss = 0;
  bit rand_rdy;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(32)) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .rx_data         (rx_data),
    .rx_data_valid   (rx_data_valid),
    .o_rx_data_ready (o_rx_data_ready),
    .o_run           (o_run),
    .o_step          (o_step),
    .o_req_valid     (o_req_valid),
    .o_req_we        (o_req_we),
    .o_req_addr      (o_req_addr),
    .o_req_wdata     (o_req_wdata),
    .req_ready       (req_ready),
    .o_err           (o_err),
    .o_err_cnt       (o_err_cnt),
    .o_busy          (o_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit         m_ok = 1'b0;
  bit         m_run, m_step, m_err, m_issue, m_we, m_acc;
  int         m_err_cnt, m_gap, m_len;
  logic [31:0] m_addr, m_wdata;
  logic [7:0] m_frame[$];

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      m_ok = 1'b1; m_run = 0; m_step = 0; m_err = 0; m_issue = 0; m_we = 0;
      m_err_cnt = 0; m_gap = 0; m_addr = 0; m_wdata = 0;
      m_frame.delete();
    end else begin
      m_acc  = rx_data_valid && !m_issue;
      m_step = 0;
      m_err  = 0;
      if (m_issue) begin
        if (req_ready) m_issue = 0;
      end else if (m_frame.size() == 0) begin
        if (m_acc) begin
          case (rx_data)
            8'h47: m_run = 1;
            8'h48: m_run = 0;
            8'h53: m_step = 1;
            8'h57, 8'h52: begin m_frame.push_back(rx_data); m_gap = 0; end
            default: m_err = 1;
          endcase
        end
      end else if (m_acc) begin
        m_frame.push_back(rx_data);
        m_gap = 0;
        m_len = (m_frame[0] == 8'h57) ? 9 : 5;
        if (m_frame.size() == m_len) begin
          m_we    = (m_frame[0] == 8'h57);
          m_addr  = {m_frame[1], m_frame[2], m_frame[3], m_frame[4]};
          m_wdata = m_we ? {m_frame[5], m_frame[6], m_frame[7], m_frame[8]} : 32'h0;
          m_issue = 1;
          m_frame.delete();
        end
      end else begin
        m_gap++;
        if (m_gap == TMO) begin
          m_frame.delete();
          m_err = 1;
        end
      end
      if (m_err && m_err_cnt < 255) m_err_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clk) begin
    if (m_ok) begin
      check("run",     32'(o_run),           32'(m_run));
      check("step",    32'(o_step),          32'(m_step));
      check("err",     32'(o_err),           32'(m_err));
      check("err_cnt", 32'(o_err_cnt),       32'(m_err_cnt));
      check("valid",   32'(o_req_valid),     32'(m_issue));
      check("ready",   32'(o_rx_data_ready), 32'(!m_issue));
      check("busy",    32'(o_busy),          32'(m_issue || (m_frame.size() != 0)));
      if (m_issue) begin
        check("we",    32'(o_req_we), 32'(m_we));
        check("addr",  o_req_addr,    m_addr);
        check("wdata", o_req_wdata,   m_wdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge sys_clk);
    if (rand_rdy) req_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_data       = b;
    rx_data_valid = 1'b1;
    while (!o_rx_data_ready && guard < 1000) begin
      tick();
      guard++;
    end
    if (guard >= 1000) begin
      n_vec++; n_miss++;
      $display("FAIL send_wait: ready stuck at %0d, expected 1", o_rx_data_ready);
    end
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) tick();
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_gap(w[31:24]); send_gap(w[23:16]); send_gap(w[15:8]); send_gap(w[7:0]);
  endtask

  int          r, k;
  logic [31:0] ra, rd;

  initial begin
    sys_rst_n = 0; rx_data = 0; rx_data_valid = 0; req_ready = 0; rand_rdy = 0;
    repeat (3) tick();
    sys_rst_n = 1;
    tick();
    check("rst_run",   32'(o_run), 0);
    check("rst_errc",  32'(o_err_cnt), 0);
    check("rst_ready", 32'(o_rx_data_ready), 1);
    check("rst_busy",  32'(o_busy), 0);

    // run / step / halt
    send_byte(8'h47);
    check("t1_run_up", 32'(o_run), 1);
    repeat (100) tick();
    send_byte(8'h53);
    check("t1_step", 32'(o_step), 1);
    check("t1_run_kept", 32'(o_run), 1);
    tick();
    check("t1_step_off", 32'(o_step), 0);
    send_byte(8'h48);
    check("t1_run_down", 32'(o_run), 0);
    check("t1_errc", 32'(o_err_cnt), 0);

    // write with stalled memory side
    req_ready = 0;
    send_byte(8'h57); send_word(32'h0000_0010); send_word(32'hDEAD_BEEF);
    check("t2_valid", 32'(o_req_valid), 1);
    check("t2_we",    32'(o_req_we), 1);
    check("t2_addr",  o_req_addr, 32'h0000_0010);
    check("t2_wdata", o_req_wdata, 32'hDEAD_BEEF);
    repeat (20) begin
      tick();
      check("t2_bp", 32'(o_rx_data_ready), 0);
    end
    req_ready = 1;
    tick();
    req_ready = 0;
    check("t2_done", 32'(o_req_valid), 0);

    // read with memory side ready
    req_ready = 1;
    send_byte(8'h52); send_word(32'h8000_0004);
    check("t3_valid", 32'(o_req_valid), 1);
    check("t3_we",    32'(o_req_we), 0);
    check("t3_addr",  o_req_addr, 32'h8000_0004);
    check("t3_wdata", o_req_wdata, 32'h0);
    tick();
    check("t3_done", 32'(o_req_valid), 0);
    req_ready = 0;

    // timeout mid-frame
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    repeat (TMO + 10) tick();
    check("t4_errc", 32'(o_err_cnt), 1);
    check("t4_idle", 32'(o_busy), 0);
    send_byte(8'h47);
    check("t4_go", 32'(o_run), 1);

    // randomized frames
    rand_rdy = 1;
    repeat (40) begin
      r = $urandom_range(0, 9);
      ra = $urandom(); rd = $urandom();
      case (r)
        0: send_gap(8'h47);
        1: send_gap(8'h48);
        2: send_gap(8'h53);
        3, 4: begin send_gap(8'h57); send_word(ra); send_word(rd); end
        5, 6: begin send_gap(8'h52); send_word(ra); end
        7: send_gap(8'($urandom_range(0, 255)));
        default: begin
          send_gap((r == 8) ? 8'h57 : 8'h52);
          k = $urandom_range(0, 3);
          for (int i = 0; i < k; i++) send_gap(8'($urandom_range(0, 255)));
          repeat (TMO + 3) tick();
        end
      endcase
    end
    rand_rdy = 0;
    req_ready = 1;
    repeat (TMO + 5) tick();
    req_ready = 0;

    // error count saturation
    send_byte(8'h78);
    repeat (300) send_byte(8'h00);
    check("t5_sat", 32'(o_err_cnt), 255);
    tick();

    // reset mid-frame
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'hAA);
    sys_rst_n = 0;
    tick();
    check("t6_busy",  32'(o_busy), 0);
    check("t6_errc",  32'(o_err_cnt), 0);
    check("t6_valid", 32'(o_req_valid), 0);
    check("t6_run",   32'(o_run), 0);
    sys_rst_n = 1;
    repeat (20) tick();
    check("t6_noreq", 32'(o_req_valid), 0);

    // reset during ISSUE
    req_ready = 0;
    send_byte(8'h47);
    send_byte(8'h52); send_word(32'h1234_5678);
    repeat (3) tick();
    check("t6b_issue", 32'(o_req_valid), 1);
    sys_rst_n = 0;
    tick();
    check("t6b_valid", 32'(o_req_valid), 0);
    check("t6b_run",   32'(o_run), 0);
    check("t6b_errc",  32'(o_err_cnt), 0);
    sys_rst_n = 1;
    req_ready = 1;
    repeat (10) tick();
    check("t6b_noreq", 32'(o_req_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
